mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_pkg.sv | 23 ++
 rtl/mul_div_datapath.sv | 89 ++++++++
 rtl/mul_div_unit.sv | 84 ++++++++
 tb/tb_mul_div_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes, FSM states and default widths.
package mul_div_unit_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

endpackage

// File: rtl/mul_div_datapath.sv
// Radix-2 shift-add multiplier / restoring divider with sign fix-up.
// Results are presented combinationally; the FSM decides when to commit them.
module mul_div_datapath
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   rem_q;
  logic               is_div_q, neg_res_q, neg_rem_q, dz_q;

  logic               is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem_s;

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = is_signed && a[WIDTH-1];
    b_neg     = is_signed && b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    addend    = acc_q[0] ? opnd_q : '0;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
    div_sh    = {rem_q, acc_q[WIDTH-1]};
    div_ge    = div_sh >= {1'b0, opnd_q};
    div_diff  = div_sh[WIDTH-1:0] - opnd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      rem_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (load) begin
      is_div_q  <= is_div;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      dz_q      <= is_div && (b == '0);
      if (is_div) begin
        opnd_q <= b_mag;
        acc_q  <= {{WIDTH{1'b0}}, a_mag};
        // Divide by zero skips the iterations: the dividend becomes the remainder.
        rem_q  <= (b == '0) ? a_mag : '0;
      end else begin
        opnd_q <= a_mag;
        acc_q  <= {{WIDTH{1'b0}}, b_mag};
        rem_q  <= '0;
      end
    end else if (step) begin
      if (is_div_q) begin
        rem_q              <= div_ge ? div_diff : div_sh[WIDTH-1:0];
        acc_q[WIDTH-1:0]   <= {acc_q[WIDTH-2:0], div_ge};
      end else begin
        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod   = neg_res_q ? -acc_q : acc_q;
    quo    = dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_s  = neg_rem_q ? -rem_q : rem_q;
    hi_res = is_div_q ? rem_s : prod[2*WIDTH-1:WIDTH];
    lo_res = is_div_q ? quo : prod[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit: control FSM, iteration counter, HI/LO
// registers and the Busy/Done handshake around mul_div_datapath.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             load, step, is_muldiv, is_div;
  logic [WIDTH-1:0] hi_res, lo_res;

  mul_div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (Clk),
    .rst    (Reset),
    .load   (load),
    .step   (step),
    .op     (Op),
    .a      (A),
    .b      (B),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  always_comb begin
    is_div    = (Op == OP_DIV) || (Op == OP_DIVU);
    is_muldiv = Start && ((Op == OP_MULT) || (Op == OP_MULTU) || is_div);
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_muldiv) begin
          load    = 1'b1;
          state_d = (is_div && (B == '0)) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (cnt_q == '1) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      HI      <= '0;
      LO      <= '0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      Done    <= (state_q == S_FIX);
      if (load)      cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == S_FIX) begin
        HI <= hi_res;
        LO <= lo_res;
      end else if (state_q == S_IDLE && Start) begin
        if (Op == OP_MTHI) HI <= A;
        if (Op == OP_MTLO) LO <= A;
      end
    end
  end

  assign Busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed cases plus random operations
// checked against a plain-arithmetic model of HI/LO results.
module tb_mul_div_unit;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] expq[$];
  logic [31:0] hi_m = '0, lo_m = '0;
  logic        done_prev = 1'b0;

  mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Returns {HI, LO} from the architectural definition of each operation.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] u;
    case (op)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      3'd1: begin
        u = {32'h0, a} * {32'h0, b};
        return u;
      end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge Clk) begin
    if (Done) begin
      chk("done_width", {63'h0, done_prev}, 64'h0);
      if (expq.size() == 0) begin
        chk("unexpected_done", {HI, LO}, 64'h0);
        if ({HI, LO} === 64'h0) begin
          bad++;
          $display("FAIL unexpected_done got=Done want=no Done");
        end
      end else begin
        chk("result_hilo", {HI, LO}, expq.pop_front());
      end
    end
    done_prev = Done;
  end

  // Issues one request at a negedge and waits for it to complete.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
    if (op <= 3'd3) begin
      expq.push_back(model(op, a, b));
      {hi_m, lo_m} = model(op, a, b);
      n = 0;
      while (Busy && n < 100) begin
        n++;
        @(negedge Clk);
      end
      chk("busy_len", 64'(n), (op[1] && b == 0) ? 64'd1 : 64'd33);
      chk("hilo_after_op", {HI, LO}, {hi_m, lo_m});
    end else begin
      if (op == 3'd4) hi_m = a;
      if (op == 3'd5) lo_m = a;
      chk("nonmd_busy_done", {62'h0, Busy, Done}, 64'h0);
      chk("nonmd_hilo", {HI, LO}, {hi_m, lo_m});
    end
  endtask

  initial begin
    int n;
    int dseen;
    Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_state", {Busy, Done, HI, LO}, 66'h0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd0, 32'hFFFF_FFF9, 32'd6);
    run_op(3'd4, 32'h0000_1234, 32'd0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd3, 32'd100, 32'd7);
    run_op(3'd3, 32'd55, 32'd0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'd0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd5, 32'hCAFE_F00D, 32'd0);
    run_op(3'd6, 32'h1111_1111, 32'd3);

    // A move-to-LO arriving mid-multiply must be dropped.
    Start = 1'b1; Op = 3'd1; A = 32'd3; B = 32'd5;
    @(negedge Clk);
    Start = 1'b0;
    expq.push_back(model(3'd1, 32'd3, 32'd5));
    {hi_m, lo_m} = model(3'd1, 32'd3, 32'd5);
    n = 0;
    for (int c = 0; c < 100 && Busy; c++) begin
      if (c == 9) begin Start = 1'b1; Op = 3'd5; A = 32'd9; end
      else Start = 1'b0;
      n++;
      @(negedge Clk);
    end
    Start = 1'b0;
    chk("busy_len_ignored_start", 64'(n), 64'd33);
    chk("ignored_mtlo_hilo", {HI, LO}, {32'd0, 32'd15});

    for (int i = 0; i < 60; i++) run_op(3'($urandom_range(0, 7)), pick(), pick());

    // Reset in the middle of a divide abandons it with no completion.
    Start = 1'b1; Op = 3'd3; A = 32'd1000; B = 32'd10;
    @(negedge Clk);
    Start = 1'b0;
    repeat (19) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_state", {Busy, Done, HI, LO}, 66'h0);
    hi_m = '0; lo_m = '0;
    dseen = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) dseen++;
    end
    chk("abort_no_done", 64'(dseen), 64'd0);
    chk("abort_hilo_held", {HI, LO}, 64'h0);

    run_op(3'd3, 32'd1000, 32'd10);
    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
